// File: rtl/median_window_feeder.sv
// median_window_feeder: buffers two raster lines and serialises each interior 3x3 window
// as 9 DI words under DSI, stalling the stream until the median stage reports DONE.
module median_window_feeder #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] DI,
    output logic             DSI,
    input  logic             DONE
);
    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);

    typedef enum logic [1:0] {ACCEPT, SHIFT, WAIT} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    col, cur_col, nxt_col;
    logic [1:0]       row, cur_row, nxt_row;
    logic [3:0]       cnt;
    logic             acc, win, wrap;
    logic [WIDTH-1:0] lb0 [IMG_W];
    logic [WIDTH-1:0] lb1 [IMG_W];
    logic [WIDTH-1:0] w [9];

    // in_sof forces the accepted pixel to (0,0); row saturates at 2 since only row>=2 matters
    always_comb begin
        in_ready = state == ACCEPT;
        acc      = in_valid & in_ready;
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        wrap     = cur_col == LAST;
        nxt_col  = wrap ? '0 : cur_col + 1'b1;
        nxt_row  = wrap ? ((cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1) : cur_row;
        win      = (cur_row == 2'd2) && (cur_col >= CW'(2));
        state_nx = state == ACCEPT ? ((acc && win) ? SHIFT : ACCEPT) :
                   state == SHIFT  ? ((cnt == 4'd8) ? WAIT : SHIFT) :
                   (DONE ? ACCEPT : WAIT);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ACCEPT;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            col <= '0;
            row <= '0;
            cnt <= '0;
            DI  <= '0;
            DSI <= 1'b0;
        end else begin
            if (acc) begin
                col <= nxt_col;
                row <= nxt_row;
            end
            cnt <= (state == SHIFT) ? cnt + 4'd1 : 4'd0;
            DSI <= state == SHIFT;
            if (state == SHIFT) DI <= w[cnt];
        end
    end

    // line buffers and window are storage only; row gating keeps stale data out of windows
    always_ff @(posedge CLK) begin
        if (acc) begin
            lb0[cur_col] <= lb1[cur_col];
            lb1[cur_col] <= in_data;
            w[0] <= w[1];
            w[1] <= w[2];
            w[2] <= lb0[cur_col];
            w[3] <= w[4];
            w[4] <= w[5];
            w[5] <= lb1[cur_col];
            w[6] <= w[7];
            w[7] <= w[8];
            w[8] <= in_data;
        end
    end
endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
- Upstream stage of the median datapath. Accepts a raster pixel stream through a valid/ready handshake and buffers two image lines.
- Builds a 3x3 neighbourhood for every interior pixel position.
- Serialises each window into the median stage as 9 consecutive words on DI with DSI high.
- Stalls the stream until the median control reports completion on DONE.

Parameters:
- WIDTH, 8, pixel width in bits; matches the median datapath word.
- IMG_W, 640, pixels per image line; must be >= 3.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  raster pixel, row-major.
- in_valid  in  1  in_data is valid.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (row 0, col 0).
- in_ready  out  1  feeder accepts a pixel this cycle; transfer when in_valid & in_ready.
- DI  out  WIDTH  serialised window word to the median datapath.
- DSI  out  1  high for exactly 9 cycles per window while DI carries window data.
- DONE  in  1  single-cycle pulse from median control: result taken, next window may load.

Behaviour:
- Reset (async, nRST=0):
  - state=ACCEPT, col=0, row=0, shift count=0.
  - DI=0, DSI=0, in_ready=1.
  - Line buffers are not reset; rows 0-1 gating makes stale contents unused.
- Storage:
  - Two line buffers, LB0 (row r-2) and LB1 (row r-1), each IMG_W x WIDTH.
  - 3x3 window register array w[0..8], row-major: w0 = top-left, w8 = bottom-right.
- Accept of pixel p at column c (state ACCEPT, in_valid=1):
  - New right column = {LB0[c], LB1[c], p} (top, mid, bottom).
  - Existing window columns shift left.
  - LB0[c] <= LB1[c]; LB1[c] <= p.
- Position counters:
  - If in_sof is set, the accepted pixel is col 0, row 0; its write and shift proceed normally.
  - Otherwise col increments. At col = IMG_W-1 it wraps to 0 and row increments.
  - row saturates at 2, since only row >= 2 matters.
  - Frame height is not tracked.
- Window-complete condition: accepted pixel has row >= 2 and col >= 2. Windows never straddle lines.
- FSM:
  - ACCEPT: in_ready=1, DSI=0. An accept meeting the window-complete condition goes to SHIFT with count=0. Any other accept stays in ACCEPT.
  - SHIFT: in_ready=0. Registered outputs DSI=1, DI=w[count]. count runs 0..8; after the count=8 word the state goes to WAIT.
  - WAIT: in_ready=0, DSI=0, DI holds its last value. DONE=1 returns to ACCEPT on the next edge.
- Latency and DSI timing:
  - A window-completing accept at edge t puts w0 on DI at t+1 and w8 at t+9.
  - DSI is high during cycles t+1..t+9 and low at t+10.
- Handshake and boundary rules:
  - DONE in ACCEPT or SHIFT is ignored; no state change.
  - in_valid held high while in_ready=0 is not consumed; the upstream source holds the data.
  - in_sof mid-line or mid-frame restarts the counters. No windows are emitted until row 2 col 2 of the new frame.
  - Reset mid-SHIFT or mid-WAIT: DSI drops to 0 immediately (async). The window is discarded and the FSM restarts in ACCEPT.
  - Window contents are frozen outside ACCEPT, because there are no accepts then.

Test Plan (IMG_W=4, WIDTH=8, pixel value = 16*row+col):
- Reset, then stream rows 0-2 with in_valid=1 and in_sof on the first pixel:
  - in_ready stays 1 through pixel (2,1).
  - After accepting (2,2), in_ready=0 and DSI=1 for 9 cycles with DI = 00,01,02,10,11,12,20,21,22.
  - Then DSI=0 and the feeder holds until DONE.
- Pulse DONE, hold (2,3) valid:
  - Accepted on the cycle after DONE.
  - DI = 01,02,03,11,12,13,21,22,23.
- Continue with row 3 pixels (3,0),(3,1),(3,2):
  - No DSI after (3,0) or (3,1).
  - After (3,2), DI = 10,11,12,20,21,22,30,31,32.
- Assert DONE during SHIFT and again 2 cycles into WAIT:
  - The SHIFT pulse is ignored.
  - The WAIT pulse returns in_ready=1 exactly one cycle later.
- Assert in_sof at pixel (3,1) with value 0xAA:
  - Counters restart; no window is emitted until new-frame pixel (2,2).
  - The first new window contains only new-frame data.
- Drive nRST low during the 5th SHIFT cycle:
  - DSI=0 and DI=0 immediately.
  - After release, in_ready=1 and no residual DSI pulses.
